// File: rtl/uart_program_loader.sv
// uart_program_loader
//
// Serial boot loader placed in front of the instruction memory. It receives a
// framed program image on an 8N1 UART line, packs the data bytes into
// little-endian 32-bit words and writes them to consecutive word addresses
// starting at byte address 0. The core is held in reset while a load runs and
// is released once the image is complete.
//
// Frame: 0xA5, count[7:0], count[15:8], count*4 data bytes, [checksum].
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   - a trailing checksum byte (XOR of all data bytes) is expected;
//               a mismatch ends the load in ERROR.
//   undefined - no checksum byte; the load completes after the last word.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   uart_rx      serial input, idle high, LSB first, asynchronous to clk
//   load_req     one-cycle pulse that starts a load (from IDLE/DONE/ERROR)
//   imem_we      one-cycle write strobe per assembled word
//   imem_addr    byte address of the word being written
//   imem_wdata   word being written
//   cpu_resetn   active-low core reset, low while loading or after an error
//   busy         high while a load is in progress
//   done         high after a successful load
//   error        high after a failed load
//   words_loaded number of words written in the current or last load

module uart_program_loader #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    input  logic        load_req,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int               BIT_CYCLES  = CLK_FREQ_HZ / BAUD;
    localparam int               CNT_W       = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [15:0]      DEPTH_LIMIT = 16'(DEPTH_WORDS);
    localparam logic [7:0]       SYNC_BYTE   = 8'hA5;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_next;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]       rx_bit_idx, rx_bit_next;
    logic [7:0]       rx_shift, rx_shift_next;
    logic             byte_valid, byte_valid_next;
    logic             frame_err, frame_err_next;
    logic [7:0]       rx_byte;

    assign rx_byte = rx_shift;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rx_state_next   = rx_state;
        rx_cnt_next     = rx_cnt + 1'b1;
        rx_bit_next     = rx_bit_idx;
        rx_shift_next   = rx_shift;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev && !rx_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                // Recheck mid-start-bit; a line already back high was a glitch.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    rx_bit_next   = rx_bit_idx + 1'b1;
                    if (rx_bit_idx == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_state_next   = RX_IDLE;
                    byte_valid_next = rx_sync;
                    frame_err_next  = !rx_sync;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, independent of order.
        if (!resetn) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state   <= rx_state_next;
            rx_cnt     <= rx_cnt_next;
            rx_bit_idx <= rx_bit_next;
            rx_shift   <= rx_shift_next;
            byte_valid <= byte_valid_next;
            frame_err  <= frame_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;
    localparam state_t AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR
    } state_t;
    localparam state_t AFTER_DATA = S_DONE;
`endif

    state_t      state, state_next;
    logic        start_load;
    logic        receiving;
    logic [15:0] count;
    logic [15:0] len_word;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_acc;
`endif

    assign len_word  = {rx_byte, count[7:0]};
    assign receiving = !(state inside {S_IDLE, S_DONE, S_ERROR});
    assign busy      = receiving;
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);

    always_comb begin
        state_next = state;
        start_load = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_req) begin
                    state_next = S_SYNC;
                    start_load = 1'b1;
                end
            end
            S_SYNC: begin
                if (byte_valid && rx_byte == SYNC_BYTE) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (byte_valid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (byte_valid) begin
                    if (len_word > DEPTH_LIMIT)  state_next = S_ERROR;
                    else if (len_word == 16'd0) state_next = AFTER_DATA;
                    else                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                // Leave on the write cycle of the final word.
                if (imem_we && (words_loaded + 16'd1 == count)) state_next = AFTER_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (byte_valid) state_next = (rx_byte == csum_acc) ? S_DONE : S_ERROR;
            end
`endif
            default: state_next = S_IDLE;
        endcase
        if (receiving && frame_err) state_next = S_ERROR;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the datapath registers are all reset; they are few, and a
        // clean known state after an aborted load keeps the outputs defined.
        if (!resetn) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_resetn   <= 1'b0;
            words_loaded <= '0;
            count        <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_acc     <= '0;
`endif
        end else begin
            imem_we    <= 1'b0;
            // The core runs only in IDLE (existing image) and DONE.
            cpu_resetn <= (state_next == S_IDLE) || (state_next == S_DONE);

            if (start_load) begin
                imem_addr    <= '0;
                words_loaded <= '0;
                byte_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_acc     <= '0;
`endif
            end

            if (state == S_LEN_LO && byte_valid) count[7:0]  <= rx_byte;
            if (state == S_LEN_HI && byte_valid) count[15:8] <= rx_byte;

            if (state == S_DATA && byte_valid) begin
                word_buf[{byte_idx, 3'b000} +: 8] <= rx_byte;
                byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                csum_acc <= csum_acc ^ rx_byte;
`endif
                if (byte_idx == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= {rx_byte, word_buf[23:0]};
                end
            end

            // Address and count advance after the write cycle so both are
            // stable while imem_we is high.
            if (imem_we) begin
                imem_addr    <= imem_addr + 32'd4;
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule
